// File: rtl/bcd_display_mux.sv
// Two-digit multiplexed seven-segment driver with blanking gaps and coherent per-frame digit snapshot.
// Latency: pins registered; a new input pair is shown at most one frame plus GAP_CYCLES after it settles.
// Backpressure: none; free-running display consumer, enable=0 parks the sequencer dark at GAP_U.
module bcd_display_mux #(
  parameter int NBITS          = 4,
  parameter int REFRESH_DIV    = 50000,
  parameter int GAP_CYCLES     = 500,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             blank_lz,
  input  logic [NBITS-1:0] counter_u,
  input  logic [NBITS-1:0] counter_d,
  output logic [6:0]       seg,
  output logic [1:0]       an
);

  // One dwell timer serves both gap and show states, so size it for the longer of the two.
  localparam int TMAX = (REFRESH_DIV > GAP_CYCLES) ? REFRESH_DIV : GAP_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] SHOW_LAST = TW'(REFRESH_DIV - 1);

  // Pin polarity masks; XOR with the logical value gives the value driven on the board.
  localparam logic [6:0] SEG_XOR = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [1:0] AN_XOR  = (AN_ACTIVE_LOW  != 0) ? 2'b11 : 2'b00;

  typedef enum logic [1:0] {
    GAP_U  = 2'd0,
    SHOW_U = 2'd1,
    GAP_D  = 2'd2,
    SHOW_D = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [TW-1:0]    timer;
  logic             dwell_last;
  logic             snap;
  logic [NBITS-1:0] shadow_u;
  logic [NBITS-1:0] shadow_d;
  logic [NBITS-1:0] disp_u;
  logic [NBITS-1:0] disp_d;
  logic [6:0]       seg_nxt;
  logic [1:0]       an_nxt;

  // Logical gfedcba pattern; anything outside 0-9 is shown as a dash.
  function automatic logic [6:0] decode(input logic [NBITS-1:0] d);
    logic [6:0] s;
    case (32'(d))
      0:       s = 7'h3F;
      1:       s = 7'h06;
      2:       s = 7'h5B;
      3:       s = 7'h4F;
      4:       s = 7'h66;
      5:       s = 7'h6D;
      6:       s = 7'h7D;
      7:       s = 7'h07;
      8:       s = 7'h7F;
      9:       s = 7'h6F;
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  // Next state and next logical outputs, computed for the state being entered so the
  // registered pins change on the same edge as the state register.
  always_comb begin
    dwell_last = 1'b0;
    state_nxt  = state;
    seg_nxt    = 7'h00;
    an_nxt     = 2'b00;

    if (state == GAP_U || state == GAP_D) begin
      dwell_last = (timer == GAP_LAST);
    end else begin
      dwell_last = (timer == SHOW_LAST);
    end

    if (dwell_last) begin
      case (state)
        GAP_U:   state_nxt = SHOW_U;
        SHOW_U:  state_nxt = GAP_D;
        GAP_D:   state_nxt = SHOW_D;
        default: state_nxt = GAP_U;
      endcase
    end

    // Both shadows load together on entry to SHOW_U; the digit shown on that
    // entry edge must come from the values being captured, not the stale shadow.
    snap   = dwell_last && (state == GAP_U);
    disp_u = snap ? counter_u : shadow_u;
    disp_d = snap ? counter_d : shadow_d;

    case (state_nxt)
      SHOW_U: begin
        an_nxt  = 2'b01;
        seg_nxt = decode(disp_u);
      end
      SHOW_D: begin
        if (blank_lz && (disp_d == '0)) begin
          an_nxt  = 2'b00;
          seg_nxt = 7'h00;
        end else begin
          an_nxt  = 2'b10;
          seg_nxt = decode(disp_d);
        end
      end
      default: begin
        an_nxt  = 2'b00;
        seg_nxt = 7'h00;
      end
    endcase
  end

  // Sequencer, shadow registers and registered pins; reset beats enable, and both go dark immediately.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= GAP_U;
      timer    <= '0;
      shadow_u <= '0;
      shadow_d <= '0;
      seg      <= SEG_XOR;
      an       <= AN_XOR;
    end else if (!enable) begin
      state <= GAP_U;
      timer <= '0;
      seg   <= SEG_XOR;
      an    <= AN_XOR;
    end else begin
      state <= state_nxt;
      timer <= dwell_last ? '0 : timer + 1'b1;
      if (snap) begin
        shadow_u <= counter_u;
        shadow_d <= counter_d;
      end
      seg <= seg_nxt ^ SEG_XOR;
      an  <= an_nxt ^ AN_XOR;
    end
  end

endmodule

// File: tb/tb_bcd_display_mux.sv
// Directed bench for bcd_display_mux with REFRESH_DIV=8, GAP_CYCLES=2, active-low pins.
// Frame is 20 cycles: phases 0-1 dark, 2-9 units, 10-11 dark, 12-19 tens.
// Outputs sampled on the falling edge; inputs driven on the falling edge.
module tb_bcd_display_mux;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       blank_lz;
  logic [3:0] counter_u;
  logic [3:0] counter_d;
  logic [6:0] seg;
  logic [1:0] an;

  int checks;
  int failures;
  int k;            // phase counter of the most recent sample since sequencer restart

  logic [6:0] es;
  logic [1:0] ea;

  bcd_display_mux #(
    .NBITS(4),
    .REFRESH_DIV(8),
    .GAP_CYCLES(2),
    .SEG_ACTIVE_LOW(1),
    .AN_ACTIVE_LOW(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .blank_lz(blank_lz),
    .counter_u(counter_u),
    .counter_d(counter_d),
    .seg(seg),
    .an(an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected pin values at a given frame phase; u_pins/d_pins are hand-computed pin codes.
  function automatic void exp_at(input int ph, input logic [6:0] u_pins, input logic [6:0] d_pins,
                                 input bit d_dark, output logic [6:0] e_seg, output logic [1:0] e_an);
    if (ph >= 2 && ph < 10) begin
      e_seg = u_pins;
      e_an  = 2'b10;
    end else if (ph >= 12 && ph < 20 && !d_dark) begin
      e_seg = d_pins;
      e_an  = 2'b01;
    end else begin
      e_seg = 7'h7F;
      e_an  = 2'b11;
    end
  endfunction

  task automatic test_reset;
    reset     = 1'b1;
    enable    = 1'b1;
    blank_lz  = 1'b0;
    counter_u = 4'd7;
    counter_d = 4'd4;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (seg !== 7'h7F) begin
        failures++;
        $display("FAIL reset_seg cycle %0d: got %h expected 7f", i, seg);
      end
      checks++;
      if (an !== 2'b11) begin
        failures++;
        $display("FAIL reset_an cycle %0d: got %b expected 11", i, an);
      end
    end
    k     = 0;
    reset = 1'b0;
  endtask

  // Two full frames with 7/4: units pins ~07=78, tens pins ~66=19.
  task automatic test_sequence;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      k++;
      exp_at(k % 20, 7'h78, 7'h19, 1'b0, es, ea);
      checks++;
      if (seg !== es || an !== ea) begin
        failures++;
        $display("FAIL sequence k=%0d: got seg=%h an=%b expected seg=%h an=%b", k, seg, an, es, ea);
      end
    end
  endtask

  // Units 3 captured at frame start; both digits change mid SHOW_U and must appear together next frame.
  task automatic test_snapshot;
    logic [6:0] up;
    logic [6:0] dp;
    counter_u = 4'd3;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      k++;
      up = (k < 60) ? 7'h30 : 7'h19;   // ~4F then ~66
      dp = (k < 60) ? 7'h19 : 7'h12;   // ~66 then ~6D
      exp_at(k % 20, up, dp, 1'b0, es, ea);
      checks++;
      if (seg !== es || an !== ea) begin
        failures++;
        $display("FAIL snapshot k=%0d: got seg=%h an=%b expected seg=%h an=%b", k, seg, an, es, ea);
      end
      if (k == 45) begin
        counter_u = 4'd4;
        counter_d = 4'd5;
      end
    end
  endtask

  // Tens 0 with blank_lz=1 stays dark; blank_lz drops mid SHOW_D and tens (pins 40) appears next edge.
  task automatic test_blank_lz;
    counter_u = 4'd1;
    counter_d = 4'd0;
    blank_lz  = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      k++;
      exp_at(k % 20, (k < 81) ? 7'h19 : 7'h79, (k < 81) ? 7'h12 : 7'h40, (k <= 95) && (k > 81), es, ea);
      checks++;
      if (seg !== es || an !== ea) begin
        failures++;
        $display("FAIL blank_lz k=%0d: got seg=%h an=%b expected seg=%h an=%b", k, seg, an, es, ea);
      end
      if (k == 95) blank_lz = 1'b0;
    end
  endtask

  // Units 12 decodes to dash (pins 3F); tens 9 gives pins ~6F=10.
  task automatic test_dash;
    counter_u = 4'd12;
    counter_d = 4'd9;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      k++;
      exp_at(k % 20, 7'h3F, 7'h10, 1'b0, es, ea);
      checks++;
      if (seg !== es || an !== ea) begin
        failures++;
        $display("FAIL dash k=%0d: got seg=%h an=%b expected seg=%h an=%b", k, seg, an, es, ea);
      end
    end
  endtask

  // Reset mid SHOW_D, then enable dropped mid SHOW_U; each goes dark on the next edge and restarts cleanly.
  task automatic test_reset_enable;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      k++;
      exp_at(k % 20, 7'h3F, 7'h10, 1'b0, es, ea);
      checks++;
      if (seg !== es || an !== ea) begin
        failures++;
        $display("FAIL pre_reset k=%0d: got seg=%h an=%b expected seg=%h an=%b", k, seg, an, es, ea);
      end
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (seg !== 7'h7F || an !== 2'b11) begin
      failures++;
      $display("FAIL mid_show_reset: got seg=%h an=%b expected seg=7f an=11", seg, an);
    end
    reset = 1'b0;
    k     = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      k++;
      exp_at(k % 20, 7'h3F, 7'h10, 1'b0, es, ea);
      checks++;
      if (seg !== es || an !== ea) begin
        failures++;
        $display("FAIL post_reset k=%0d: got seg=%h an=%b expected seg=%h an=%b", k, seg, an, es, ea);
      end
    end
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (seg !== 7'h7F || an !== 2'b11) begin
        failures++;
        $display("FAIL disabled cycle %0d: got seg=%h an=%b expected seg=7f an=11", i, seg, an);
      end
    end
    enable = 1'b1;
    k      = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      k++;
      exp_at(k % 20, 7'h3F, 7'h10, 1'b0, es, ea);
      checks++;
      if (seg !== es || an !== ea) begin
        failures++;
        $display("FAIL re_enable k=%0d: got seg=%h an=%b expected seg=%h an=%b", k, seg, an, es, ea);
      end
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    k         = 0;
    reset     = 1'b1;
    enable    = 1'b1;
    blank_lz  = 1'b0;
    counter_u = 4'd0;
    counter_d = 4'd0;
    test_reset;
    test_sequence;
    test_snapshot;
    test_blank_lz;
    test_dash;
    test_reset_enable;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_display_mux.md
# bcd_display_mux

Two-digit multiplexed seven-segment driver that consumes the units/tens BCD digits produced by the BCD counter and drives a shared segment bus plus per-digit anode enables on the 50 MHz board. It runs a timed state machine that alternates the digits with blanking gaps to prevent ghosting. Both digits are snapshotted coherently once per frame so a counter carry never tears the display. It sits between the counter and the board's display pins.

## Interface
- NBITS, 4, width of each BCD digit input
- REFRESH_DIV, 50000, clk cycles each digit is shown (1 ms at 50 MHz); must be >= 1
- GAP_CYCLES, 500, clk cycles of all-anodes-off between digits; must be >= 1
- SEG_ACTIVE_LOW, 1, 1 = seg outputs inverted (common-anode board)
- AN_ACTIVE_LOW, 1, 1 = an outputs inverted
- clk  input  1  system clock, 50 MHz
- reset  input  1  synchronous, active-high reset
- enable  input  1  1 = run; 0 = hold in reset state with display dark
- blank_lz  input  1  1 = suppress tens digit when it is 0
- counter_u  input  NBITS  units digit, BCD
- counter_d  input  NBITS  tens digit, BCD
- seg  output  7  segments {g,f,e,d,c,b,a} (logical, before polarity)
- an  output  2  an[0] = units, an[1] = tens (logical, before polarity)

## Operation
- States: GAP_U (dark, next shows units), SHOW_U, GAP_D (dark, next shows tens), SHOW_D.
- Cycle: GAP_U -> SHOW_U -> GAP_D -> SHOW_D -> GAP_U. Frame = 2*(REFRESH_DIV+GAP_CYCLES) cycles.
- Dwell timer counts 0..N-1 in each state (N = GAP_CYCLES for gaps, REFRESH_DIV for shows); on count N-1 the state advances and the timer returns to 0.
- Snapshot: on the edge entering SHOW_U, shadow_u <= counter_u and shadow_d <= counter_d together. Shadows hold for the entire frame; input changes at other times are not displayed until the next frame.
- Decode (logical, active-high, gfedcba): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F; any value 10-15 = 40 (dash).
- SHOW_U: an = 01, seg = decode(shadow_u).
- SHOW_D: an = 10, seg = decode(shadow_d); if blank_lz = 1 and shadow_d = 0 then an = 00, seg = 00.
- GAP_U/GAP_D: an = 00, seg = 00.
- Pin polarity: seg pin = logical ^ {7{SEG_ACTIVE_LOW}}; an pin = logical ^ {2{AN_ACTIVE_LOW}}.
- blank_lz is sampled every cycle (not snapshotted).
- enable = 0: state forced to GAP_U, timer 0, outputs dark; shadows retain value. On enable rising, sequence restarts exactly as after reset.
- reset has priority over enable.

## Timing
- Reset (sync, 1 edge): state GAP_U, timer 0, shadow_u = shadow_d = 0, logical an = 00, seg = 00 (pins 7F / 11 with default active-low).
- seg and an are registered and change on the same edge the state register changes; no combinational path from inputs to pins.
- After reset deasserts at edge E0 (first edge with reset = 0 and enable = 1 is E1), SHOW_U is entered at edge E(GAP_CYCLES); units digit visible from then for REFRESH_DIV cycles.
- Anode on and off never overlap: between any an[0] high and an[1] high there are exactly GAP_CYCLES dark cycles.
- Reset or enable drop mid-SHOW: outputs dark on that same edge; no partial digit completes.
- Input-to-display latency: at most one frame plus GAP_CYCLES.

## Test plan
- Params REFRESH_DIV=8, GAP_CYCLES=2, active-low. Reset 3 cycles -> seg pins 7F, an pins 11 throughout; after release, 2 dark cycles then an pins 10 for 8 cycles, 2 dark, an pins 01 for 8 cycles, repeating every 20 cycles.
- counter_u=7, counter_d=4 held -> SHOW_U seg pins = ~07 = 78; SHOW_D seg pins = ~66 = 19.
- Change counter_u 3->4 in the middle of SHOW_U -> displayed digit stays 3 until the next SHOW_U entry, then shows 4; tens and units always update on the same edge.
- counter_d=0, blank_lz=1 -> an stays dark during SHOW_D; blank_lz=0 -> tens shows 3F logical (pins 40).
- counter_u=12 -> units shows dash (logical 40, pins 3F).
- Assert reset for 1 cycle mid-SHOW_D, then drop enable for 5 cycles -> dark on the next edge each time; after enable returns, the first visible digit is units after exactly 2 gap cycles.
